// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter for the shared wishbone memory port: video and sound DMA
// bursts plus CPU single-word cycles, with a CPU anti-starvation guard.
module mem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CPU_GUARD = 2
) (
  input  logic        clkcpu,
  input  logic        rst_i,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  output logic        vid_ack,
  input  logic        snd_req,
  input  logic [21:0] snd_addr,
  output logic        snd_ack,
  input  logic        cpu_cyc,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [21:0] cpu_addr,
  input  logic [31:0] cpu_dat,
  output logic        cpu_ack,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [2:0]  mem_cti_o,
  output logic [21:0] mem_addr_o,
  output logic [31:0] mem_dat_o,
  input  logic        mem_ack_i,
  output logic [1:0]  owner_o,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a memory word transfers on any rising edge where
  // mem_cyc_o & mem_stb_o & mem_ack_i; outputs hold until that edge.

  localparam int LB = $clog2(BURST_LEN);
  localparam int GW = (CPU_GUARD < 1) ? 1 : $clog2(CPU_GUARD + 1);
  localparam logic [LB-1:0] LAST_BEAT = LB'(BURST_LEN - 1);
  localparam logic [LB-1:0] PENULT_BEAT = LB'(BURST_LEN - 2);
  localparam logic [GW-1:0] GUARD_MAX = GW'(CPU_GUARD);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID = 2'd1;
  localparam logic [1:0] OWN_SND = 2'd2;
  localparam logic [1:0] OWN_CPU = 2'd3;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_VID  = 3'd1,
    S_SND  = 3'd2,
    S_CPU  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_guard;
  logic [LB-1:0]   r_beat;

  logic            w_cpu_req;
  logic            w_guard_hit;
  logic            w_grant_cpu;
  logic            w_grant_vid;
  logic            w_grant_snd;
  logic [21:0]     w_dma_addr;
  logic            w_dma_state;

  assign w_cpu_req   = cpu_cyc & cpu_stb;
  assign w_guard_hit = w_cpu_req && (r_guard == GUARD_MAX);
  assign w_grant_cpu = w_guard_hit || (w_cpu_req && !vid_req && !snd_req);
  assign w_grant_vid = !w_guard_hit && vid_req;
  assign w_grant_snd = !w_guard_hit && !vid_req && snd_req;
  assign w_dma_addr  = vid_req ? vid_addr : snd_addr;
  assign w_dma_state = (r_state == S_VID) || (r_state == S_SND);

  assign vid_ack     = mem_ack_i & (r_state == S_VID);
  assign snd_ack     = mem_ack_i & (r_state == S_SND);
  assign cpu_ack     = mem_ack_i & (r_state == S_CPU);
  assign dbg_state_o = r_state;

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_guard    <= '0;
      r_beat     <= '0;
      mem_cyc_o  <= 1'b0;
      mem_stb_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_sel_o  <= 4'h0;
      mem_cti_o  <= 3'b000;
      mem_addr_o <= '0;
      mem_dat_o  <= '0;
      owner_o    <= OWN_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Guard counts DMA wins that overtook a waiting CPU.
          if (!w_cpu_req || w_grant_cpu)
            r_guard <= '0;
          else if (r_guard != GUARD_MAX)
            r_guard <= r_guard + GW'(1);

          if (w_grant_cpu) begin
            r_state    <= S_CPU;
            owner_o    <= OWN_CPU;
            mem_cyc_o  <= 1'b1;
            mem_stb_o  <= 1'b1;
            mem_we_o   <= cpu_we;
            mem_sel_o  <= cpu_sel;
            mem_cti_o  <= CTI_CLASSIC;
            mem_addr_o <= cpu_addr;
            mem_dat_o  <= cpu_dat;
          end else if (w_grant_vid || w_grant_snd) begin
            r_state    <= w_grant_vid ? S_VID : S_SND;
            owner_o    <= w_grant_vid ? OWN_VID : OWN_SND;
            mem_cyc_o  <= 1'b1;
            mem_stb_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= 4'hF;
            mem_cti_o  <= CTI_INCR;
            mem_addr_o <= w_dma_addr;
            r_beat     <= '0;
          end
        end

        S_VID, S_SND: begin
          if (mem_ack_i) begin
            if (r_beat == LAST_BEAT) begin
              r_state   <= S_GAP;
              owner_o   <= OWN_NONE;
              mem_cyc_o <= 1'b0;
              mem_stb_o <= 1'b0;
              mem_cti_o <= CTI_CLASSIC;
            end else begin
              r_beat <= r_beat + LB'(1);
              // Low address bits wrap inside the aligned block; upper bits hold.
              mem_addr_o[LB-1:0] <= mem_addr_o[LB-1:0] + LB'(1);
              if (r_beat == PENULT_BEAT)
                mem_cti_o <= CTI_END;
            end
          end
        end

        S_CPU: begin
          // A withdrawn CPU request abandons the cycle without an ack.
          if (mem_ack_i || !w_cpu_req) begin
            r_state   <= S_GAP;
            owner_o   <= OWN_NONE;
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            mem_we_o  <= 1'b0;
          end
        end

        S_GAP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state   <= S_IDLE;
          owner_o   <= OWN_NONE;
          mem_cyc_o <= 1'b0;
          mem_stb_o <= 1'b0;
        end
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_dma_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a wait-state memory model, an expected-beat
// queue filled by the stimulus, and a monitor that pops on every accepted word.
module tb_mem_port_arbiter;

  localparam int W = 67;

  logic        clkcpu;
  logic        rst_i;
  logic        vid_req;
  logic [21:0] vid_addr;
  logic        vid_ack;
  logic        snd_req;
  logic [21:0] snd_addr;
  logic        snd_ack;
  logic        cpu_cyc;
  logic        cpu_stb;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [21:0] cpu_addr;
  logic [31:0] cpu_dat;
  logic        cpu_ack;
  logic        mem_cyc_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [2:0]  mem_cti_o;
  logic [21:0] mem_addr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i;
  logic [1:0]  owner_o;
  logic [2:0]  dbg_state_o;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_vid = 0;
  int n_snd = 0;
  int n_cpu = 0;
  int cyc_n = 0;
  int ws = 0;
  int mem_wait = 0;

  mem_port_arbiter #(.BURST_LEN(4), .CPU_GUARD(2)) dut (
    .clkcpu(clkcpu), .rst_i(rst_i),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_ack(cpu_ack),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_cti_o(mem_cti_o), .mem_addr_o(mem_addr_o),
    .mem_dat_o(mem_dat_o), .mem_ack_i(mem_ack_i), .owner_o(owner_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and reset-independent cycle counter
  initial begin
    clkcpu = 1'b0;
    forever #5 clkcpu = ~clkcpu;
  end

  initial forever begin
    @(posedge clkcpu);
    cyc_n++;
  end

  // Memory model: acks after ws wait cycles, back-to-back when ws == 0
  initial begin
    mem_ack_i = 1'b0;
    forever begin
      @(negedge clkcpu);
      if (mem_cyc_o === 1'b1 && mem_stb_o === 1'b1) begin
        if (mem_wait == ws) begin
          mem_ack_i = 1'b1;
          mem_wait = 0;
        end else begin
          mem_ack_i = 1'b0;
          mem_wait++;
        end
      end else begin
        mem_ack_i = 1'b0;
        mem_wait = 0;
      end
    end
  end

  function automatic logic [W-1:0] pack(input logic [1:0] own, input logic [2:0] acks,
                                        input logic we, input logic [3:0] sel,
                                        input logic [2:0] cti, input logic [21:0] addr,
                                        input logic [31:0] dat);
    return {own, acks, we, sel, cti, addr, dat};
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted word against the head of the expected queue
  initial forever begin
    logic [W-1:0] act;
    @(negedge clkcpu);
    #1;
    if (rst_i === 1'b0) begin
      if (vid_ack === 1'b1) n_vid++;
      if (snd_ack === 1'b1) n_snd++;
      if (cpu_ack === 1'b1) n_cpu++;
      if (mem_cyc_o === 1'b1 && mem_stb_o === 1'b1 && mem_ack_i === 1'b1) begin
        act = pack(owner_o, {vid_ack, snd_ack, cpu_ack}, mem_we_o, mem_sel_o, mem_cti_o,
                   mem_addr_o, (owner_o == 2'd3) ? mem_dat_o : 32'h0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", act);
        end else begin
          check("beat", act, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_burst(input logic [1:0] own, input logic [21:0] start);
    logic [21:0] a;
    for (int i = 0; i < 4; i++) begin
      a = start;
      a[1:0] = start[1:0] + 2'(i);
      exp_q.push_back(pack(own, (own == 2'd1) ? 3'b100 : 3'b010, 1'b0, 4'hF,
                           (i == 3) ? 3'b111 : 3'b010, a, 32'h0));
    end
  endtask

  // Bounded wait: sel 0/1/2 = vid/snd/cpu ack count, 3 = owner_o
  task automatic wait_for(input int sel, input int val, input string nm);
    int cur;
    for (int t = 0; t < 300; t++) begin
      @(negedge clkcpu);
      #2;
      case (sel)
        0: cur = n_vid;
        1: cur = n_snd;
        2: cur = n_cpu;
        default: cur = int'(owner_o);
      endcase
      if (cur == val) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL timeout_%s: got %0d expected %0d", nm, cur, val);
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [3:0] sel,
                         input logic [21:0] addr, input logic [31:0] dat);
    cpu_cyc = req;
    cpu_stb = req;
    cpu_we = we;
    cpu_sel = sel;
    cpu_addr = addr;
    cpu_dat = dat;
  endtask

  initial begin
    int t0;
    int base;
    int hold;
    rst_i = 1'b1;
    vid_req = 1'b0;
    snd_req = 1'b0;
    vid_addr = '0;
    snd_addr = '0;
    cpu_set(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);

    // Reset state
    repeat (3) @(posedge clkcpu);
    #1;
    check("rst_strobes", {62'h0, mem_cyc_o, mem_stb_o, mem_we_o, owner_o}, '0);
    check("rst_fields", {8'h0, mem_sel_o, mem_cti_o, mem_addr_o, mem_dat_o}, '0);
    check("rst_acks", {64'h0, vid_ack, snd_ack, cpu_ack}, '0);
    @(negedge clkcpu);
    rst_i = 1'b0;

    // Video only at 0x106 with zero-wait memory, request held to see the dead time
    ws = 0;
    base = n_vid;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pack(2'd1, 3'b100, 1'b0, 4'hF, 3'b010, 22'h000106, 32'h0));
      exp_q.push_back(pack(2'd1, 3'b100, 1'b0, 4'hF, 3'b010, 22'h000107, 32'h0));
      exp_q.push_back(pack(2'd1, 3'b100, 1'b0, 4'hF, 3'b010, 22'h000104, 32'h0));
      exp_q.push_back(pack(2'd1, 3'b100, 1'b0, 4'hF, 3'b111, 22'h000105, 32'h0));
    end
    vid_addr = 22'h000106;
    vid_req = 1'b1;
    wait_for(0, base + 4, "vid_burst1");
    @(posedge clkcpu);
    #1;
    check("gap_cycle1", {64'h0, mem_cyc_o, owner_o}, '0);
    @(posedge clkcpu);
    #1;
    check("gap_cycle2", {64'h0, mem_cyc_o, owner_o}, '0);
    @(posedge clkcpu);
    #1;
    check("regrant", {39'h0, mem_cyc_o, owner_o, mem_cti_o, mem_addr_o},
          {39'h0, 1'b1, 2'd1, 3'b010, 22'h000106});
    @(negedge clkcpu);
    vid_req = 1'b0;
    wait_for(0, base + 8, "vid_burst2");

    // All three request together: video, sound, then CPU
    base = n_cpu;
    push_burst(2'd1, 22'h011112);
    push_burst(2'd2, 22'h022221);
    exp_q.push_back(pack(2'd3, 3'b001, 1'b0, 4'hF, 3'b000, 22'h033330, 32'h12345678));
    @(negedge clkcpu);
    vid_addr = 22'h011112;
    snd_addr = 22'h022221;
    vid_req = 1'b1;
    snd_req = 1'b1;
    cpu_set(1'b1, 1'b0, 4'hF, 22'h033330, 32'h12345678);
    wait_for(3, 1, "own_vid");
    vid_req = 1'b0;
    wait_for(3, 2, "own_snd");
    snd_req = 1'b0;
    wait_for(3, 3, "own_cpu");
    wait_for(2, base + 1, "cpu_ack_prio");
    @(posedge clkcpu);
    @(negedge clkcpu);
    cpu_set(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);

    // Continuous video with a pending CPU: vid, vid, cpu, vid, vid, cpu
    repeat (2) @(negedge clkcpu);
    base = n_cpu;
    for (int k = 0; k < 2; k++) begin
      push_burst(2'd1, 22'h0ABC13);
      push_burst(2'd1, 22'h0ABC13);
      exp_q.push_back(pack(2'd3, 3'b001, 1'b0, 4'hF, 3'b000, 22'h123456, 32'h0BADF00D));
    end
    vid_addr = 22'h0ABC13;
    vid_req = 1'b1;
    cpu_set(1'b1, 1'b0, 4'hF, 22'h123456, 32'h0BADF00D);
    t0 = cyc_n;
    wait_for(2, base + 1, "guard_cpu1");
    check("cpu_latency1", {66'h0, (cyc_n - t0) <= 15}, {66'h0, 1'b1});
    @(posedge clkcpu);
    t0 = cyc_n;
    wait_for(2, base + 2, "guard_cpu2");
    check("cpu_latency2", {66'h0, (cyc_n - t0) <= 15}, {66'h0, 1'b1});
    @(posedge clkcpu);
    @(negedge clkcpu);
    vid_req = 1'b0;
    cpu_set(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);

    // CPU write with 3 wait states
    repeat (3) @(negedge clkcpu);
    ws = 3;
    base = n_cpu;
    hold = 0;
    exp_q.push_back(pack(2'd3, 3'b001, 1'b1, 4'b0010, 3'b000, 22'h2AAAAA, 32'hDEADBEEF));
    cpu_set(1'b1, 1'b1, 4'b0010, 22'h2AAAAA, 32'hDEADBEEF);
    for (int t = 0; t < 20; t++) begin
      @(negedge clkcpu);
      #2;
      if (mem_cyc_o && mem_stb_o && mem_we_o && mem_sel_o == 4'b0010 &&
          mem_dat_o == 32'hDEADBEEF && owner_o == 2'd3)
        hold++;
      if (cpu_ack) break;
    end
    check("write_hold", W'(hold), W'(4));
    @(posedge clkcpu);
    @(negedge clkcpu);
    cpu_set(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
    repeat (4) @(negedge clkcpu);
    check("write_ack_count", W'(n_cpu - base), W'(1));

    // CPU withdraws before the memory acks: abandoned, no cpu_ack
    ws = 6;
    base = n_cpu;
    cpu_set(1'b1, 1'b0, 4'hF, 22'h001000, 32'h0);
    wait_for(3, 3, "own_cpu_abort");
    cpu_set(1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
    @(posedge clkcpu);
    #1;
    check("abort_release", {64'h0, mem_cyc_o, owner_o}, '0);
    repeat (8) @(negedge clkcpu);
    check("abort_no_ack", W'(n_cpu - base), W'(0));

    // Reset after the second sound word
    ws = 1;
    base = n_snd;
    push_burst(2'd2, 22'h3FFFFE);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    snd_addr = 22'h3FFFFE;
    snd_req = 1'b1;
    wait_for(3, 2, "own_snd_rst");
    snd_req = 1'b0;
    wait_for(1, base + 2, "snd_two_acks");
    @(posedge clkcpu);
    @(negedge clkcpu);
    rst_i = 1'b1;
    @(posedge clkcpu);
    #1;
    check("rst_mid_burst", {63'h0, mem_cyc_o, mem_stb_o, owner_o}, '0);
    @(negedge clkcpu);
    rst_i = 1'b0;
    repeat (6) @(negedge clkcpu);
    check("no_snd_after_rst", W'(n_snd - base), W'(2));

    // Video after reset is granted normally
    ws = 0;
    base = n_vid;
    push_burst(2'd1, 22'h000040);
    vid_addr = 22'h000040;
    vid_req = 1'b1;
    wait_for(3, 1, "own_vid_post_rst");
    vid_req = 1'b0;
    wait_for(0, base + 4, "vid_post_rst");

    repeat (4) @(negedge clkcpu);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single external wishbone memory port between video DMA, sound DMA and CPU requesters in the Archimedes core. It sits between the address-translation/DMA-address logic and the SDRAM wishbone port and issues fixed-length incrementing bursts for DMA and single-word cycles for the CPU. Fixed priority with a CPU anti-starvation guard bounds CPU latency during heavy video fetch.

## Interface

Parameters:

- `BURST_LEN`, default 4. DMA burst length in words; power of two, 2..8.
- `CPU_GUARD`, default 2. Consecutive DMA grants allowed while the CPU is pending before the CPU is forced next.

Ports. One clock; reset is synchronous and active-high. Clock port is `clkcpu`, reset port is `rst_i`.

- `clkcpu` in 1: system clock.
- `rst_i` in 1: synchronous active-high reset.
- `vid_req` in 1: video DMA request, level.
- `vid_addr` in 22 [23:2]: video burst start word address.
- `vid_ack` out 1: one pulse per video word delivered.
- `snd_req` in 1: sound DMA request, level.
- `snd_addr` in 22 [23:2]: sound burst start word address.
- `snd_ack` out 1: one pulse per sound word.
- `cpu_cyc`, `cpu_stb`, `cpu_we` in 1 each: CPU wishbone request.
- `cpu_sel` in 4: CPU byte enables.
- `cpu_addr` in 22 [23:2]: CPU word address.
- `cpu_dat` in 32: CPU write data.
- `cpu_ack` out 1: CPU cycle complete.
- `mem_cyc_o`, `mem_stb_o`, `mem_we_o` out 1 each: memory wishbone strobes.
- `mem_sel_o` out 4: byte enables.
- `mem_cti_o` out 3: cycle type.
- `mem_addr_o` out 22 [23:2]: word address.
- `mem_dat_o` out 32: write data.
- `mem_ack_i` in 1: memory acknowledge.
- `owner_o` out 2: current bus owner. 0 = none, 1 = video, 2 = sound, 3 = CPU.

## Operation

- States:
  - IDLE
  - VID (burst)
  - SND (burst)
  - CPU (single)
  - GAP (one turnaround cycle)
- Arbitration happens in IDLE only. The CPU request is `cpu_cyc & cpu_stb`.
- Priority order: video, then sound, then CPU.
- Priority exception: if `guard_cnt == CPU_GUARD` and the CPU request is set, the CPU wins over both DMA requesters.
- `guard_cnt` (sized to hold `CPU_GUARD`):
  - Increments on each DMA grant while the CPU request is set.
  - Clears on a CPU grant.
  - Clears on any IDLE cycle in which the CPU request is clear.
  - Saturates at `CPU_GUARD`.
- On a DMA grant:
  - Latch the start address.
  - The burst is aligned to `BURST_LEN` words. Low address bits `[log2(BURST_LEN)+1:2]` come from a word counter that starts at the latched start value and wraps within the aligned block. Upper bits are held.
  - `mem_we_o = 0`, `mem_sel_o = 4'hF`.
- DMA burst control:
  - `mem_cti_o = 3'b010` on every word except the last, which uses `3'b111`.
  - Each `mem_ack_i` advances the word counter.
  - The `BURST_LEN`-th ack ends the burst and moves to GAP.
- A DMA burst always completes once granted. `vid_req` or `snd_req` dropping mid-burst has no effect.
- On a CPU grant:
  - Latch `cpu_addr`, `cpu_sel`, `cpu_we`, `cpu_dat`.
  - `mem_cti_o = 3'b000`.
  - The first `mem_ack_i` moves to GAP.
  - If the CPU request drops before the ack, the state returns to GAP on the next edge, no `cpu_ack` is produced, and any stale `mem_ack_i` in GAP is ignored.
- Ack routing (combinational):
  - `vid_ack = mem_ack_i & (state == VID)`
  - `snd_ack = mem_ack_i & (state == SND)`
  - `cpu_ack = mem_ack_i & (state == CPU)`
- GAP lasts one cycle with `mem_cyc_o = mem_stb_o = 0`, then IDLE.
- `owner_o` is registered and tracks the state: VID = 1, SND = 2, CPU = 3, otherwise 0.
- Reset values: all `mem_*` outputs 0, `owner_o = 0`, state IDLE, `guard_cnt = 0`, word counter 0.
- Reset mid-burst: on the reset edge, `mem_cyc_o` and `mem_stb_o` drop and the state goes to IDLE. No further acks are forwarded.
- Simultaneous requests in IDLE follow the priority rule. Requests arriving during GAP wait for IDLE.

## Timing

- All `mem_*` outputs and `owner_o` are registered. Acks are combinational from `mem_ack_i`.
- Request sampled in IDLE at edge N gives `mem_cyc_o`, `mem_stb_o` and the address valid after edge N. This is one cycle of latency.
- Address and CTI update on the edge following each `mem_ack_i`.
- `mem_stb_o` stays high through the whole burst. Wait states are absorbed by holding until ack.
- After the last ack at edge M: GAP at M+1, IDLE at M+2. The next grant is visible after M+2, so the minimum dead bus time is 2 cycles.
- Zero-wait burst occupancy is `BURST_LEN + 2` cycles from grant to the next possible grant.

## Test plan

- Video only, `vid_addr = 0x000106`, zero-wait memory:
  - Addresses 0x106, 0x107, 0x104, 0x105.
  - CTI 010, 010, 010, 111.
  - 4 `vid_ack` pulses, then `mem_cyc_o` low for 2 cycles.
- Video, sound and CPU all requesting in the same IDLE cycle: video burst first, then sound, then CPU single (CTI 000). `owner_o` sequence 1, 2, 3.
- Continuous `vid_req` plus CPU pending with `CPU_GUARD = 2`: pattern is video, video, CPU, video, video, CPU. `cpu_ack` occurs within 2 × (`BURST_LEN` + 2) + 3 cycles.
- CPU write, `cpu_sel = 4'b0010`, `cpu_dat = 0xDEADBEEF`, memory inserts 3 wait states:
  - `mem_we_o = 1`, `mem_sel_o = 4'b0010`, `mem_dat_o = 0xDEADBEEF` held 4 cycles.
  - Single `cpu_ack`.
- `rst_i` asserted after the 2nd ack of a sound burst:
  - `mem_cyc_o = 0` and `owner_o = 0` the next cycle.
  - No further `snd_ack`.
  - A new `vid_req` after reset is granted normally.
